md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Sequencing controller for the execute stage's multiply and divide units.
- Launches the unit, tracks completion and generates the execute-stage stall (eu_stall).
- Captures and holds the result while the next stage back-pressures, and aborts in-flight work on flush.
- Sits between the decode/execute pipeline register and the Mul/Div instances; the execute stage takes eu_stall and md_out directly from it.

Parameters:
- MUL_LAT, 2, fixed multiplier latency in cycles from mul_start to valid mul_out (≥1).
- DIV_MAX, 40, divide watchdog; a divide that has not completed after this many cycles is force-completed with a zero result.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute register holds a valid, non-excepting instruction
- req_is_mul  in  1  instruction is a multiply
- req_is_div  in  1  instruction is a divide
- req_op  in  2  mul: 0=LO,1=HI,2=HIU; div: 0=Q,1=QU,2=R,3=RU
- req_a  in  32  forwarded rj
- req_b  in  32  forwarded rkd
- flush  in  1  pipeline flush for the execute stage
- next_rdy_in  in  1  memory1 stage can accept
- mul_start  out  1  one-cycle launch pulse to the multiplier
- div_start  out  1  one-cycle launch pulse to the divider
- md_signed  out  1  signedness to the units
- unit_kill  out  1  abort in-flight unit operation
- mul_out  in  64  multiplier product
- div_done  in  1  divider completion pulse
- div_q  in  32  quotient
- div_r  in  32  remainder
- eu_stall  out  1  execute stage must hold its instruction
- md_done  out  1  md_out is valid for the current instruction
- md_out  out  32  selected result

Behaviour:
- Reset: state=IDLE, counter=0, md_out=0. All outputs are 0.
- States: IDLE, MUL, DIV, HOLD.
- Signedness: md_signed = 1 for mul LO/HI and div Q/R; 0 for HIU, QU, RU.
- IDLE transitions, when req_valid & ~flush:
  - req_is_mul: mul_start=1 combinationally, counter=1, go to MUL.
  - req_is_div and req_b≠0: div_start=1, counter=1, go to DIV.
  - req_is_div and req_b=0: no unit launch. Latch md_out = 0 for Q/QU, or req_a for R/RU. Go to HOLD.
  - eu_stall = req_valid & (req_is_mul | req_is_div) & ~flush in IDLE.
- MUL:
  - Counter increments each cycle; eu_stall=1 while counter<MUL_LAT.
  - When counter==MUL_LAT: latch md_out = mul_out[31:0] for LO, mul_out[63:32] for HI/HIU. Go to HOLD.
- DIV:
  - eu_stall=1. Counter increments each cycle.
  - On div_done: latch div_q for Q/QU, div_r for R/RU. Go to HOLD.
  - If counter reaches DIV_MAX without div_done: latch 0, pulse unit_kill, go to HOLD.
- HOLD:
  - md_done=1, eu_stall=0.
  - If next_rdy_in, go to IDLE; the instruction leaves at this edge. Otherwise stay, and md_out stays stable.
  - HOLD never relaunches a unit, even though req_valid remains high.
- Overall latency (start to HOLD): mul = MUL_LAT+1 cycles; div = divider latency+1; div-by-zero = 1.
- flush in any state:
  - unit_kill=1 that cycle if the state is MUL or DIV.
  - Next state=IDLE, counter=0, no start pulse is issued.
  - flush overrides a coincident div_done and counter expiry.
- A new request may launch in the cycle immediately after HOLD→IDLE.
- start pulses never assert outside IDLE, so there is at most one op in flight.
- Non-mul/div instructions: eu_stall=0, md_done=0, state stays IDLE.
- Reset mid-operation: immediately returns to the reset state. Units are reset by the same rst_n.

Test Plan:
- mul LO, a=0xFFFFFFFE, b=3, next_rdy_in=1, MUL_LAT=2 → mul_start pulses once; eu_stall high 2 cycles; md_out=0xFFFFFFFA with md_done 1 cycle; back to IDLE.
- div R, a=17, b=5; model divider asserts div_done after 33 cycles; next_rdy_in=0 for 4 extra cycles → md_out=2 held 5 cycles in HOLD; no second div_start.
- div QU, b=0 → no div_start; md_done next cycle with md_out=0. div RU, a=0x1234, b=0 → md_out=0x1234.
- flush at cycle 10 of a divide → unit_kill=1 that cycle, state IDLE next cycle, md_done never asserts. A new mul the next cycle launches normally.
- divider never responds → forced completion at cycle 40 with md_out=0 and unit_kill pulse.
- rst_n low during MUL → all outputs 0 asynchronously; after release, IDLE with no spurious start.

Source files
------------

// File: rtl/md_sched.sv
// -----------------------------------------------------------------------------
// md_sched - sequencing controller for the execute-stage multiply/divide units.
//
// Launches the multiplier or divider, tracks completion, drives the execute
// stage stall, captures the result and holds it while memory1 back-pressures.
// A flush aborts any in-flight unit operation.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid         execute register holds a valid, non-excepting instr
//   req_is_mul/div    instruction class
//   req_op[1:0]       mul: 0=LO 1=HI 2=HIU ; div: 0=Q 1=QU 2=R 3=RU
//   req_a, req_b      forwarded operands
//   flush             execute-stage flush
//   next_rdy_in       memory1 can accept
//   mul_start         one-cycle multiplier launch
//   div_start         one-cycle divider launch
//   md_signed         signedness presented to the units
//   unit_kill         abort in-flight unit operation
//   mul_out           multiplier product
//   div_done/q/r      divider completion pulse, quotient, remainder
//   eu_stall          execute stage must hold its instruction
//   md_done           md_out valid for the current instruction
//   md_out            selected result
//
// State   | meaning
// --------+----------------------------------------------------------------
// IDLE    | no op in flight; may launch a unit from the execute register
// MUL     | multiplier running, fixed latency counted by r_cnt
// DIV     | divider running, waiting for div_done or the watchdog
// HOLD    | result captured in md_out, waiting for next_rdy_in
// -----------------------------------------------------------------------------
module md_sched #(
    parameter int MUL_LAT = 2,
    parameter int DIV_MAX = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_is_mul,
    input  logic        req_is_div,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    input  logic        next_rdy_in,
    output logic        mul_start,
    output logic        div_start,
    output logic        md_signed,
    output logic        unit_kill,
    input  logic [63:0] mul_out,
    input  logic        div_done,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic        eu_stall,
    output logic        md_done,
    output logic [31:0] md_out
);

    localparam int CNT_MAX = (DIV_MAX > MUL_LAT) ? DIV_MAX : MUL_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_op;
    logic [31:0]   r_md_out;

    logic w_idle;
    logic w_accept;
    logic w_mul_go;
    logic w_div_go;
    logic w_req_signed;
    logic w_busy;
    logic w_div_expire;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_busy   = (r_state == ST_MUL) || (r_state == ST_DIV);
    // Request-derived outputs are gated by rst_n so they read 0 while in reset
    // even if the execute register still shows a request.
    assign w_accept = rst_n & w_idle & req_valid & ~flush;
    assign w_mul_go = w_accept & req_is_mul;
    assign w_div_go = w_accept & ~req_is_mul & req_is_div & (req_b != 32'd0);

    // mul: LO/HI signed, HIU unsigned; div: Q/R signed, QU/RU unsigned (op[0]).
    assign w_req_signed = req_is_mul ? (req_op != 2'd2) : ~req_op[0];

    // Watchdog expiry only counts when the divider did not answer this cycle.
    assign w_div_expire = (r_state == ST_DIV) & ~div_done & (r_cnt >= CW'(DIV_MAX));

    assign mul_start = w_mul_go;
    assign div_start = w_div_go;
    assign md_signed = rst_n & req_valid & w_req_signed;
    assign unit_kill = (w_busy & flush) | w_div_expire;
    assign md_done   = (r_state == ST_HOLD);
    assign md_out    = r_md_out;

    always_comb begin
        eu_stall = 1'b0;
        case (r_state)
            ST_IDLE: eu_stall = rst_n & req_valid & (req_is_mul | req_is_div) & ~flush;
            ST_MUL:  eu_stall = (r_cnt < CW'(MUL_LAT));
            ST_DIV:  eu_stall = 1'b1;
            default: eu_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op     <= 2'd0;
            r_md_out <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && !flush) begin
                        r_op <= req_op;
                        if (req_is_mul) begin
                            r_cnt   <= CW'(1);
                            r_state <= ST_MUL;
                        end else if (req_is_div) begin
                            if (req_b != 32'd0) begin
                                r_cnt   <= CW'(1);
                                r_state <= ST_DIV;
                            end else begin
                                // Divide by zero: quotient 0, remainder is the dividend.
                                r_md_out <= req_op[1] ? req_a : 32'd0;
                                r_state  <= ST_HOLD;
                            end
                        end
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt >= CW'(MUL_LAT)) begin
                        r_md_out <= (r_op == 2'd0) ? mul_out[31:0] : mul_out[63:32];
                        r_cnt    <= '0;
                        r_state  <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else if (div_done) begin
                        r_md_out <= r_op[1] ? div_r : div_q;
                        r_cnt    <= '0;
                        r_state  <= ST_HOLD;
                    end else if (w_div_expire) begin
                        r_md_out <= 32'd0;
                        r_cnt    <= '0;
                        r_state  <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                    if (flush || next_rdy_in) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched.sv
module tb_md_sched;

    localparam int MUL_LAT = 2;
    localparam int DIV_MAX = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_is_mul = 1'b0;
    logic        req_is_div = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        flush = 1'b0;
    logic        next_rdy_in = 1'b0;
    logic        mul_start, div_start, md_signed, unit_kill;
    logic [63:0] mul_out;
    logic        div_done;
    logic [31:0] div_q, div_r;
    logic        eu_stall, md_done;
    logic [31:0] md_out;

    int n_assert = 0;
    int n_fail   = 0;
    int div_lat_cfg = 0;   // 0 = divider never answers

    always #5 clk = ~clk;

    md_sched #(.MUL_LAT(MUL_LAT), .DIV_MAX(DIV_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_is_mul(req_is_mul), .req_is_div(req_is_div),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .flush(flush), .next_rdy_in(next_rdy_in),
        .mul_start(mul_start), .div_start(div_start), .md_signed(md_signed),
        .unit_kill(unit_kill), .mul_out(mul_out),
        .div_done(div_done), .div_q(div_q), .div_r(div_r),
        .eu_stall(eu_stall), .md_done(md_done), .md_out(md_out)
    );

    // Multiplier model: product visible only exactly MUL_LAT cycles after start.
    logic [63:0] m_prod;
    int          m_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_prod <= 64'd0;
        end else if (mul_start) begin
            m_prod <= {{32{md_signed & req_a[31]}}, req_a} * {{32{md_signed & req_b[31]}}, req_b};
            m_cnt  <= 1;
        end else if (unit_kill) begin
            m_cnt <= 0;
        end else if (m_cnt != 0 && m_cnt <= MUL_LAT) begin
            m_cnt <= m_cnt + 1;
        end
    end
    assign mul_out = (m_cnt == MUL_LAT) ? m_prod : 64'hDEAD_BEEF_DEAD_BEEF;

    // Divider model: done pulse div_lat_cfg cycles after start, results only then.
    logic [31:0] d_q, d_r;
    int          d_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_cnt <= 0;
            d_q   <= 32'd0;
            d_r   <= 32'd0;
        end else if (div_start) begin
            d_cnt <= 1;
            if (req_b == 32'd0) begin
                d_q <= 32'hFFFF_FFFF;
                d_r <= req_a;
            end else if (md_signed) begin
                d_q <= $signed(req_a) / $signed(req_b);
                d_r <= $signed(req_a) % $signed(req_b);
            end else begin
                d_q <= req_a / req_b;
                d_r <= req_a % req_b;
            end
        end else if (unit_kill || div_done) begin
            d_cnt <= 0;
        end else if (d_cnt != 0) begin
            d_cnt <= d_cnt + 1;
        end
    end
    assign div_done = (div_lat_cfg != 0) && (d_cnt == div_lat_cfg);
    assign div_q    = div_done ? d_q : 32'hBAD0_BAD0;
    assign div_r    = div_done ? d_r : 32'hBAD1_BAD1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result straight from the instruction semantics.
    function automatic logic [31:0] ref_result(input bit m, input logic [1:0] op,
                                               input logic [31:0] a, input logic [31:0] b,
                                               input int lat);
        longint      pa, pb;
        logic [63:0] p;
        int          sq, sr;
        if (m) begin
            pa = (op != 2'd2) ? longint'(int'(a)) : longint'({32'h0, a});
            pb = (op != 2'd2) ? longint'(int'(b)) : longint'({32'h0, b});
            p  = 64'(pa * pb);
            return (op == 2'd0) ? p[31:0] : p[63:32];
        end
        if (b == 32'd0) return op[1] ? a : 32'd0;
        if (lat == 0)   return 32'd0;
        if (op == 2'd0 || op == 2'd2) begin
            sq = int'(a) / int'(b);
            sr = int'(a) % int'(b);
            return (op == 2'd0) ? 32'(sq) : 32'(sr);
        end
        return (op == 2'd1) ? (a / b) : (a % b);
    endfunction

    // One instruction from launch until it leaves HOLD; hx = extra back-pressure cycles.
    task automatic do_op(input string nm, input bit m, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int hx);
        int          len;
        logic [31:0] exp_res;
        bit          exp_sign;
        bit          launches;
        logic [4:0]  ev;
        exp_res  = ref_result(m, op, a, b, lat);
        launches = m || (b != 32'd0);
        if (m)                  len = MUL_LAT + 1;
        else if (b == 32'd0)    len = 1;
        else if (lat == 0)      len = DIV_MAX + 1;
        else                    len = lat + 1;
        exp_sign = m ? (op != 2'd2) : (op == 2'd0 || op == 2'd2);
        div_lat_cfg = lat;
        for (int c = 0; c <= len + hx; c++) begin
            @(negedge clk);
            req_valid = 1'b1; req_is_mul = m; req_is_div = !m;
            req_op = op; req_a = a; req_b = b; flush = 1'b0;
            next_rdy_in = (c >= len + hx);
            #1;
            ev = {c == 0 && m,
                  c == 0 && !m && b != 32'd0,
                  m ? (c < MUL_LAT) : (c < len),
                  c >= len,
                  !m && b != 32'd0 && lat == 0 && c == DIV_MAX};
            check($sformatf("%s ctl c%0d", nm, c),
                  {59'd0, mul_start, div_start, eu_stall, md_done, unit_kill}, {59'd0, ev});
            if (c == 0 && launches) check($sformatf("%s signed", nm), 64'(md_signed), 64'(exp_sign));
            if (c >= len) check($sformatf("%s md_out c%0d", nm, c), 64'(md_out), 64'(exp_res));
        end
    endtask

    task automatic quiet(input string nm);
        check(nm, {59'd0, mul_start, div_start, eu_stall, md_done, unit_kill}, 64'd0);
    endtask

    initial begin : stim
        bit          m;
        logic [1:0]  op;
        logic [31:0] a, b;
        int          lat, kind;

        // Reset with a request already visible: everything must read zero.
        req_valid = 1'b1; req_is_mul = 1'b1; req_a = 32'd7; req_b = 32'd9;
        #1;
        check("reset ctl", {58'd0, mul_start, div_start, eu_stall, md_done, unit_kill, md_signed}, 64'd0);
        check("reset md_out", 64'(md_out), 64'd0);
        @(negedge clk);
        req_valid = 1'b0; req_is_mul = 1'b0;
        rst_n = 1'b1;
        #1 quiet("post-reset idle");

        // Directed cases.
        do_op("mul_lo", 1'b1, 2'd0, 32'hFFFF_FFFE, 32'd3, 0, 0);
        do_op("div_r", 1'b0, 2'd2, 32'd17, 32'd5, 33, 4);
        do_op("div_qu0", 1'b0, 2'd1, 32'h55, 32'd0, 0, 0);
        do_op("div_ru0", 1'b0, 2'd3, 32'h1234, 32'd0, 0, 0);
        do_op("mul_hi", 1'b1, 2'd1, 32'h8000_0000, 32'h0000_0003, 0, 1);
        do_op("mul_hiu", 1'b1, 2'd2, 32'h8000_0000, 32'h0000_0003, 0, 0);
        do_op("div_q_neg", 1'b0, 2'd0, 32'hFFFF_FFF1, 32'd4, 3, 0);
        do_op("div_watchdog", 1'b0, 2'd1, 32'd100, 32'd7, 0, 2);

        // Flush at cycle 10 of a divide, then a multiply right behind it.
        div_lat_cfg = 33;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            req_valid = 1'b1; req_is_mul = 1'b0; req_is_div = 1'b1;
            req_op = 2'd0; req_a = 32'd1000; req_b = 32'd3;
            next_rdy_in = 1'b1; flush = (c == 10);
            #1;
            if (c == 10) begin
                check("flush kill", 64'(unit_kill), 64'd1);
                check("flush no start", 64'(div_start), 64'd0);
            end
        end
        do_op("mul_after_flush", 1'b1, 2'd0, 32'd6, 32'd7, 0, 0);

        // Flush coinciding with div_done must discard the result.
        div_lat_cfg = 5;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            req_valid = 1'b1; req_is_mul = 1'b0; req_is_div = 1'b1;
            req_op = 2'd2; req_a = 32'd50; req_b = 32'd7; flush = (c == 5);
            #1;
            if (c == 5) check("flush+done kill", 64'(unit_kill), 64'd1);
        end
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        #1 quiet("flush+done discarded");

        // Flush in IDLE suppresses the launch.
        @(negedge clk);
        req_valid = 1'b1; req_is_mul = 1'b1; req_is_div = 1'b0; flush = 1'b1;
        #1 quiet("idle flush");
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        #1 quiet("idle flush after");

        // Non-mul/div instruction.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = 1'b1; req_is_mul = 1'b0; req_is_div = 1'b0;
            #1 quiet($sformatf("alu instr c%0d", c));
        end

        // Reset in the middle of a multiply.
        @(negedge clk);
        req_valid = 1'b1; req_is_mul = 1'b1; req_is_div = 1'b0; req_op = 2'd0;
        req_a = 32'd3; req_b = 32'd4; next_rdy_in = 1'b1;
        #1 check("rst-mid launch", 64'(mul_start), 64'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst-mid ctl", {58'd0, mul_start, div_start, eu_stall, md_done, unit_kill, md_signed}, 64'd0);
        check("rst-mid md_out", 64'(md_out), 64'd0);
        @(negedge clk);
        req_valid = 1'b0; req_is_mul = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 quiet($sformatf("rst-release c%0d", c));
            @(negedge clk);
        end

        // Randomised back-to-back operations.
        for (int k = 0; k < 30; k++) begin
            kind = $urandom_range(0, 2);
            m    = (kind == 0);
            op   = m ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
            a    = $urandom;
            b    = (kind == 2) ? 32'd0 : $urandom;
            if (kind == 1 && b == 32'd0) b = 32'd1;
            if (kind == 1 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd2;
            lat  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, DIV_MAX - 1);
            do_op($sformatf("rnd%0d", k), m, op, a, b, lat, $urandom_range(0, 3));
        end

        @(negedge clk);
        req_valid = 1'b0;
        #1 quiet("final idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
